dds_triangle_skew_calc: RTL

//  Converts a triangle duty/peak position into the Skew0/Skew1/Skew2 slope set used by the triangle DDS.
//  A sequential shared divider computes Skew1 = 2^SHIFT/Duty and Skew2 = 2^SHIFT/(2^W - Duty).

---
 rtl/dds_triangle_skew_calc_if.sv | 29 ++
 rtl/dds_triangle_skew_calc.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/dds_triangle_skew_calc_if.sv
// dds_triangle_skew_calc_if: request/result bundle between the control
// register bank (master) and the triangle skew calculator (slave).
//
// Handshake: Start acts as a request that is accepted on a rising Clk edge only
// while Busy is low (calculator idle). Duty is captured on that same edge. Busy
// is high from the cycle after acceptance until the result is ready. Done then
// pulses high for one cycle with Skew0/1/2 already updated. Requests made while
// Busy is high are dropped, not queued.
interface dds_triangle_skew_calc_if #(
  parameter int W = 18
);
  logic         Start;
  logic [W-1:0] Duty;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Skew0;
  logic [W-1:0] Skew1;
  logic [W-1:0] Skew2;

  modport master (
    output Start, Duty,
    input  Busy, Done, Skew0, Skew1, Skew2
  );

  modport slave (
    input  Start, Duty,
    output Busy, Done, Skew0, Skew1, Skew2
  );
endinterface

// File: rtl/dds_triangle_skew_calc.sv
// dds_triangle_skew_calc: turns a triangle peak position (Duty) into the
// Skew0/Skew1/Skew2 slope set for the triangle DDS. A single restoring divider
// is shared between the two quotients:
//   Skew1 = 2^SHIFT / Duty
//   Skew2 = 2^SHIFT / (2^W - Duty)
// Each quotient is saturated to W bits. The three outputs change together,
// only in the FIN state, so the DDS never sees a mixed slope set.
// Optional feature macro: SKEW_ROUND_EN. When defined, each quotient is rounded
// to nearest by adding floor(divisor/2) to the numerator. When undefined, the
// quotients are truncated. Latency is the same in both builds.
module dds_triangle_skew_calc #(
  parameter int W     = 18,
  parameter int SHIFT = 27
) (
  input  logic                    Clk,
  input  logic                    nReset,
  dds_triangle_skew_calc_if.slave bus,
  output logic [1:0]              State
);

  localparam int QW = SHIFT + 1;        // quotient / numerator width
  localparam int RW = W + 2;            // partial remainder width (holds 2*divisor)
  localparam int CW = $clog2(QW);       // quotient bit counter width

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DIV1 = 2'd1;
  localparam logic [1:0] DIV2 = 2'd2;
  localparam logic [1:0] FIN  = 2'd3;

  localparam logic [QW-1:0] ONE_SHIFT  = {1'b1, {SHIFT{1'b0}}};
  localparam logic [W:0]    FULL_SCALE = {1'b1, {W{1'b0}}};
  localparam logic [CW-1:0] LAST_BIT   = CW'(SHIFT);

  logic [1:0]    state;
  logic [W-1:0]  d_q;        // latched Duty
  logic [W:0]    divisor;    // W+1 bits so 2^W (Duty=0 on the Skew2 path) fits
  logic [QW-1:0] num;        // numerator, consumed MSB first
  logic [QW-1:0] quo;        // quotient being assembled
  logic [QW-1:0] q1;         // finished Skew1 quotient
  logic [RW-1:0] rem;
  logic [CW-1:0] cnt;

  logic [RW-1:0] rem_shift;
  logic [RW-1:0] rem_next;
  logic          take;
  logic [QW-1:0] quo_next;
  logic [W:0]    div2;
  logic [QW-1:0] num_init1;
  logic [QW-1:0] num_init2;

  logic          done_r;
  logic [W-1:0]  skew0_r;
  logic [W-1:0]  skew1_r;
  logic [W-1:0]  skew2_r;

  // Clamp a quotient to the largest W-bit value.
  function automatic logic [W-1:0] sat(input logic [QW-1:0] q);
    if (|q[QW-1:W]) sat = {W{1'b1}};
    else            sat = q[W-1:0];
  endfunction

  // One restoring-division step plus the numerators each divide phase starts from.
  always_comb begin
    rem_shift = {rem[RW-2:0], num[QW-1]};
    take      = (rem_shift >= {1'b0, divisor});
    rem_next  = take ? (rem_shift - {1'b0, divisor}) : rem_shift;
    quo_next  = {quo[QW-2:0], take};
    div2      = FULL_SCALE - {1'b0, d_q};
`ifdef SKEW_ROUND_EN
    num_init1 = ONE_SHIFT + QW'(bus.Duty >> 1);
    num_init2 = ONE_SHIFT + QW'(div2 >> 1);
`else
    num_init1 = ONE_SHIFT;
    num_init2 = ONE_SHIFT;
`endif
  end

  // Sequencer and shared divider datapath: IDLE -> DIV1 -> DIV2 -> FIN -> IDLE.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state   <= IDLE;
      d_q     <= '0;
      divisor <= '0;
      num     <= '0;
      quo     <= '0;
      q1      <= '0;
      rem     <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start) begin
            d_q     <= bus.Duty;
            divisor <= {1'b0, bus.Duty};
            num     <= num_init1;
            quo     <= '0;
            rem     <= '0;
            cnt     <= '0;
            state   <= DIV1;
          end
        end
        DIV1: begin
          num <= num << 1;
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            q1      <= quo_next;
            divisor <= div2;
            num     <= num_init2;
            quo     <= '0;
            rem     <= '0;
            cnt     <= '0;
            state   <= DIV2;
          end
        end
        DIV2: begin
          num <= num << 1;
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            state <= FIN;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Result registers: load all three skews together in FIN and pulse Done.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      done_r  <= 1'b0;
      skew0_r <= {1'b1, {(W-1){1'b0}}};
      skew1_r <= W'(1024);
      skew2_r <= W'(1024);
    end else begin
      done_r <= 1'b0;
      if (state == FIN) begin
        done_r  <= 1'b1;
        skew0_r <= d_q;
        skew1_r <= sat(q1);
        skew2_r <= sat(quo);
      end
    end
  end

  assign bus.Busy  = (state != IDLE);
  assign bus.Done  = done_r;
  assign bus.Skew0 = skew0_r;
  assign bus.Skew1 = skew1_r;
  assign bus.Skew2 = skew2_r;
  assign State     = state;

endmodule
